rom_port_arbiter: RTL and testbench

Two-port arbiter sharing the single combinational-read boot/program ROM between the CPU instruction-fetch port and the CPU data-load port. Grants at most one requester per cycle, drives the ROM address from the winner, and registers the ROM read data into a per-port response one cycle later. Data port has priority; a starvation counter guarantees forward progress for instruction fetch.

---
 rtl/rom_port_arbiter_if.sv | 33 +++
 rtl/rom_port_arbiter.sv | 90 +++++++++
 tb/tb_rom_port_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
// Request/grant/response bundle between the CPU fetch and load ports and the
// shared boot ROM, plus the ROM address/data pair.
interface rom_port_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rdata;

    // Requester and ROM side.
    modport master (
        output i_req, i_addr, d_req, d_addr, rom_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, rom_addr
    );

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_addr, rom_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, rom_addr
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one combinational-read ROM between instruction fetch and data load.
// Load wins conflicts unless fetch has been denied STARVE_MAX cycles in a row.
module rom_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    rom_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    logic [CNT_W-1:0] starve_cnt;
    logic             i_gnt_c;
    logic             d_gnt_c;
    logic [AW-1:0]    rom_addr_c;
    logic             i_rvalid_q;
    logic             d_rvalid_q;
    logic [DW-1:0]    i_rdata_q;
    logic [DW-1:0]    d_rdata_q;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        i_gnt_c = 1'b0;
        d_gnt_c = 1'b0;
        if (!rst) begin
            if (bus.i_req && bus.d_req) begin
                if (starve_cnt == CNT_W'(STARVE_MAX)) begin
                    i_gnt_c = 1'b1;
                end else begin
                    d_gnt_c = 1'b1;
                end
            end else if (bus.i_req) begin
                i_gnt_c = 1'b1;
            end else if (bus.d_req) begin
                d_gnt_c = 1'b1;
            end
        end
    end

    always_comb begin
        rom_addr_c = '0;
        if (i_gnt_c) begin
            rom_addr_c = bus.i_addr;
        end else if (d_gnt_c) begin
            rom_addr_c = bus.d_addr;
        end
    end

    // Counts consecutive denied fetch cycles, saturating at the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (bus.i_req && !i_gnt_c) begin
            if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Capture ROM data for the winner; rdata holds until that port's next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            i_rvalid_q <= i_gnt_c;
            d_rvalid_q <= d_gnt_c;
            if (i_gnt_c) begin
                i_rdata_q <= bus.rom_rdata;
            end
            if (d_gnt_c) begin
                d_rdata_q <= bus.rom_rdata;
            end
        end
    end

    assign bus.i_gnt    = i_gnt_c;
    assign bus.d_gnt    = d_gnt_c;
    assign bus.rom_addr = rom_addr_c;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed scenarios plus a randomized run against
// a behavioural model of the grant rules and a 4096-word ROM.
module tb_rom_port_arbiter;
    localparam int unsigned WORDS = 4096;
    localparam logic [31:0] OOR_WORD = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rom_port_arbiter_if bus4 ();
    rom_port_arbiter_if bus0 ();

    rom_port_arbiter #(.STARVE_MAX(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    rom_port_arbiter #(.STARVE_MAX(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    logic [31:0] rom [WORDS];

    assign bus4.rom_rdata = (bus4.rom_addr[31:14] == '0) ? rom[bus4.rom_addr[13:2]] : OOR_WORD;
    assign bus0.rom_rdata = (bus0.rom_addr[31:14] == '0) ? rom[bus0.rom_addr[13:2]] : OOR_WORD;

    function automatic logic [31:0] exp_rom(input logic [31:0] a);
        if ((a / 4) < WORDS) return rom[a / 4];
        return OOR_WORD;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 32'($urandom);
        return 32'($urandom_range(0, 16383));
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus4.i_req = 1'b0; bus4.d_req = 1'b0; bus4.i_addr = '0; bus4.d_addr = '0;
        bus0.i_req = 1'b0; bus0.d_req = 1'b0; bus0.i_addr = '0; bus0.d_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus4.i_req = 1'b1; bus4.i_addr = 32'd8;
        bus4.d_req = 1'b1; bus4.d_addr = 32'd12;
        #1;
        vectors++; if (bus4.i_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_i_gnt: got %b exp 0", bus4.i_gnt); end
        vectors++; if (bus4.d_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_d_gnt: got %b exp 0", bus4.d_gnt); end
        vectors++; if (bus4.rom_addr !== 32'h0) begin miscompares++; $display("FAIL rst_rom_addr: got %h exp 0", bus4.rom_addr); end
        @(posedge clk); #1;
        vectors++; if (bus4.i_rvalid !== 1'b0 || bus4.d_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b%b exp 00", bus4.i_rvalid, bus4.d_rvalid); end
        vectors++; if (bus4.i_rdata !== 32'h0 || bus4.d_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h/%h exp 0/0", bus4.i_rdata, bus4.d_rdata); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (bus4.d_gnt !== 1'b1 || bus4.i_gnt !== 1'b0) begin miscompares++; $display("FAIL rel_gnt: got i%b d%b exp i0 d1", bus4.i_gnt, bus4.d_gnt); end
        vectors++; if (bus4.rom_addr !== 32'd12) begin miscompares++; $display("FAIL rel_rom_addr: got %h exp c", bus4.rom_addr); end
        @(posedge clk); #1;
        vectors++; if (bus4.d_rvalid !== 1'b1 || bus4.d_rdata !== rom[3]) begin miscompares++; $display("FAIL rel_resp: got %b %h exp 1 %h", bus4.d_rvalid, bus4.d_rdata, rom[3]); end
    endtask

    task automatic test_single_fetch();
        reset_dut();
        bus4.i_req = 1'b1; bus4.i_addr = 32'h0;
        #1;
        vectors++; if (bus4.i_gnt !== 1'b1 || bus4.rom_addr !== 32'h0) begin miscompares++; $display("FAIL fetch_gnt: got %b %h exp 1 0", bus4.i_gnt, bus4.rom_addr); end
        @(posedge clk); #1;
        vectors++; if (bus4.i_rvalid !== 1'b1 || bus4.i_rdata !== 32'h0000_0093) begin miscompares++; $display("FAIL fetch_resp: got %b %h exp 1 00000093", bus4.i_rvalid, bus4.i_rdata); end
        @(negedge clk);
        bus4.i_req = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus4.i_rvalid !== 1'b0 || bus4.i_rdata !== 32'h0000_0093) begin miscompares++; $display("FAIL fetch_hold: got %b %h exp 0 00000093", bus4.i_rvalid, bus4.i_rdata); end
    endtask

    // Both ports held busy: four loads then one fetch, repeating.
    task automatic test_conflict();
        logic exp_i;
        reset_dut();
        bus4.i_req = 1'b1; bus4.i_addr = 32'd40;
        bus4.d_req = 1'b1; bus4.d_addr = 32'd80;
        for (int k = 0; k < 15; k++) begin
            exp_i = ((k % 5) == 4);
            #1;
            vectors++; if (bus4.i_gnt !== exp_i || bus4.d_gnt !== !exp_i) begin miscompares++; $display("FAIL conflict_gnt[%0d]: got i%b d%b exp i%b d%b", k, bus4.i_gnt, bus4.d_gnt, exp_i, !exp_i); end
            @(posedge clk); #1;
            vectors++; if (bus4.i_rvalid !== exp_i || bus4.d_rvalid !== !exp_i) begin miscompares++; $display("FAIL conflict_rv[%0d]: got i%b d%b exp i%b d%b", k, bus4.i_rvalid, bus4.d_rvalid, exp_i, !exp_i); end
            @(negedge clk);
        end
        bus4.i_req = 1'b0; bus4.d_req = 1'b0;
    endtask

    task automatic test_starve_zero();
        reset_dut();
        bus0.i_req = 1'b1; bus0.i_addr = 32'd4;
        bus0.d_req = 1'b1; bus0.d_addr = 32'd16;
        for (int k = 0; k < 6; k++) begin
            #1;
            vectors++; if (bus0.i_gnt !== 1'b1 || bus0.d_gnt !== 1'b0) begin miscompares++; $display("FAIL starve0_gnt[%0d]: got i%b d%b exp i1 d0", k, bus0.i_gnt, bus0.d_gnt); end
            @(posedge clk); @(negedge clk);
        end
        bus0.i_req = 1'b0;
        #1;
        vectors++; if (bus0.d_gnt !== 1'b1 || bus0.rom_addr !== 32'd16) begin miscompares++; $display("FAIL starve0_load: got %b %h exp 1 10", bus0.d_gnt, bus0.rom_addr); end
        @(posedge clk); #1;
        vectors++; if (bus0.d_rvalid !== 1'b1 || bus0.d_rdata !== rom[4]) begin miscompares++; $display("FAIL starve0_resp: got %b %h exp 1 %h", bus0.d_rvalid, bus0.d_rdata, rom[4]); end
        @(negedge clk);
        bus0.d_req = 1'b0;
    endtask

    task automatic test_out_of_range();
        reset_dut();
        bus4.d_req = 1'b1; bus4.d_addr = 32'h0001_0000;
        @(posedge clk); #1;
        vectors++; if (bus4.d_rvalid !== 1'b1 || bus4.d_rdata !== OOR_WORD) begin miscompares++; $display("FAIL oor_resp: got %b %h exp 1 %h", bus4.d_rvalid, bus4.d_rdata, OOR_WORD); end
        @(negedge clk);
        bus4.d_addr = 32'h0000_3FFC;
        @(posedge clk); #1;
        vectors++; if (bus4.d_rvalid !== 1'b1 || bus4.d_rdata !== rom[WORDS-1]) begin miscompares++; $display("FAIL last_word: got %b %h exp 1 %h", bus4.d_rvalid, bus4.d_rdata, rom[WORDS-1]); end
        @(negedge clk);
        bus4.d_req = 1'b0;
    endtask

    // Reset while a load response is visible; starvation history must also clear.
    task automatic test_reset_mid_op();
        logic exp_i;
        reset_dut();
        bus4.i_req = 1'b1; bus4.i_addr = 32'd20;
        bus4.d_req = 1'b1; bus4.d_addr = 32'd24;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        vectors++; if (bus4.d_rvalid !== 1'b1) begin miscompares++; $display("FAIL midop_pre: got %b exp 1", bus4.d_rvalid); end
        rst = 1'b1;
        #1;
        vectors++; if (bus4.d_rvalid !== 1'b0 || bus4.d_rdata !== 32'h0) begin miscompares++; $display("FAIL midop_async: got %b %h exp 0 0", bus4.d_rvalid, bus4.d_rdata); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_i = (k == 4);
            #1;
            vectors++; if (bus4.i_gnt !== exp_i || bus4.d_gnt !== !exp_i) begin miscompares++; $display("FAIL midop_cnt[%0d]: got i%b d%b exp i%b d%b", k, bus4.i_gnt, bus4.d_gnt, exp_i, !exp_i); end
            @(posedge clk); @(negedge clk);
        end
        bus4.i_req = 1'b0; bus4.d_req = 1'b0;
    endtask

    // Random legal traffic: a requester holds req/addr until granted.
    task automatic test_random();
        int          denied = 0;
        int          iwait = 0;
        bit          ip = 0, dp = 0, ig, dg;
        logic [31:0] ia = '0, da = '0, ea, ei = '0, ed = '0;
        reset_dut();
        for (int k = 0; k < 600; k++) begin
            if (!ip && $urandom_range(0, 3) != 0) begin ip = 1; ia = rand_addr(); iwait = 0; end
            if (!dp && $urandom_range(0, 4) != 0) begin dp = 1; da = rand_addr(); end
            bus4.i_req = ip; bus4.i_addr = ia;
            bus4.d_req = dp; bus4.d_addr = da;
            if (ip && dp) begin ig = (denied == 4); dg = !ig; end
            else begin ig = ip; dg = dp; end
            ea = ig ? ia : (dg ? da : 32'h0);
            if (ip) iwait++;
            #1;
            vectors++; if (bus4.i_gnt !== ig || bus4.d_gnt !== dg) begin miscompares++; $display("FAIL rand_gnt[%0d]: got i%b d%b exp i%b d%b", k, bus4.i_gnt, bus4.d_gnt, ig, dg); end
            vectors++; if (bus4.rom_addr !== ea) begin miscompares++; $display("FAIL rand_rom_addr[%0d]: got %h exp %h", k, bus4.rom_addr, ea); end
            if (ig) begin
                ei = exp_rom(ia);
                vectors++; if (iwait > 5) begin miscompares++; $display("FAIL rand_starve_bound[%0d]: got %0d exp <=5", k, iwait); end
            end
            if (dg) ed = exp_rom(da);
            denied = (ip && !ig) ? ((denied < 4) ? denied + 1 : 4) : 0;
            @(posedge clk); #1;
            vectors++; if (bus4.i_rvalid !== ig || bus4.i_rdata !== ei) begin miscompares++; $display("FAIL rand_i_resp[%0d]: got %b %h exp %b %h", k, bus4.i_rvalid, bus4.i_rdata, ig, ei); end
            vectors++; if (bus4.d_rvalid !== dg || bus4.d_rdata !== ed) begin miscompares++; $display("FAIL rand_d_resp[%0d]: got %b %h exp %b %h", k, bus4.d_rvalid, bus4.d_rdata, dg, ed); end
            if (ig) ip = 0;
            if (dg) dp = 0;
            @(negedge clk);
        end
        bus4.i_req = 1'b0; bus4.d_req = 1'b0;
    endtask

    initial begin
        for (int w = 0; w < int'(WORDS); w++) rom[w] = 32'($urandom);
        rom[0] = 32'h0000_0093;
        bus4.i_req = 1'b0; bus4.d_req = 1'b0; bus4.i_addr = '0; bus4.d_addr = '0;
        bus0.i_req = 1'b0; bus0.d_req = 1'b0; bus0.i_addr = '0; bus0.d_addr = '0;
        test_reset();
        test_single_fetch();
        test_conflict();
        test_starve_zero();
        test_out_of_range();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
